// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU opcodes, flag indices, FSM states and the HALT word
package cpu_pkg;
  localparam int OPSIZE    = 3;
  localparam int ALUWIDTH  = 16;
  localparam int NUMFLAGS  = 4;
  localparam int ADLINES   = 5;
  localparam int DATALINES = 16;
  localparam logic [OPSIZE-1:0] OP_PASS = 3'd0;
  localparam logic [OPSIZE-1:0] OP_AND  = 3'd1;
  localparam logic [OPSIZE-1:0] OP_OR   = 3'd2;
  localparam logic [OPSIZE-1:0] OP_XOR  = 3'd3;
  localparam logic [OPSIZE-1:0] OP_NOT  = 3'd4;
  localparam logic [OPSIZE-1:0] OP_SUB  = 3'd5;
  localparam logic [OPSIZE-1:0] OP_ADD  = 3'd6;
  localparam logic [OPSIZE-1:0] OP_SHL  = 3'd7;
  localparam logic [OPSIZE-1:0] JMP_ALWAYS = 3'd0;
  localparam logic [OPSIZE-1:0] JMP_Z      = 3'd1;
  localparam logic [OPSIZE-1:0] JMP_C      = 3'd2;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int STORE_BIT = 8;
  localparam int JUMP_BIT  = 9;
  localparam logic [DATALINES-1:0] HALT_WORD = '0;
  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_STORE, ST_HALT} state_t;
endpackage

// File: rtl/alu_module.sv
// alu_module: combinational 16-bit ALU producing result and {V,N,C,Z} flags
module alu_module
  import cpu_pkg::*;
(
  input  logic [ALUWIDTH-1:0] i_a,
  input  logic [ALUWIDTH-1:0] i_b,
  input  logic [OPSIZE-1:0]   i_op,
  output logic [ALUWIDTH-1:0] o_result,
  output logic [NUMFLAGS-1:0] o_flags
);
  logic [ALUWIDTH:0]   w_add;
  logic [ALUWIDTH:0]   w_sub;
  logic [ALUWIDTH-1:0] w_res;
  logic                w_c;
  logic                w_v;
  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      OP_PASS: w_res = i_b;
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOT:  w_res = ~i_a;
      OP_SUB: begin
        w_res = w_sub[ALUWIDTH-1:0];
        w_c   = w_sub[ALUWIDTH];
        w_v   = (i_a[ALUWIDTH-1] ^ i_b[ALUWIDTH-1]) & (w_sub[ALUWIDTH-1] ^ i_a[ALUWIDTH-1]);
      end
      OP_ADD: begin
        w_res = w_add[ALUWIDTH-1:0];
        w_c   = w_add[ALUWIDTH];
        w_v   = ~(i_a[ALUWIDTH-1] ^ i_b[ALUWIDTH-1]) & (w_add[ALUWIDTH-1] ^ i_a[ALUWIDTH-1]);
      end
      default: begin
        w_res = {i_a[ALUWIDTH-2:0], 1'b0};
        w_c   = i_a[ALUWIDTH-1];
        w_v   = i_a[ALUWIDTH-1] ^ i_a[ALUWIDTH-2];
      end
    endcase
  end
  assign o_result = w_res;
  assign o_flags  = {w_v, w_res[ALUWIDTH-1], w_c, w_res == '0};
endmodule

// File: rtl/cu_module.sv
// cu_module: fetch/decode/execute control unit of the 16-bit accumulator CPU
// Build option CU_JUMP_EN: IR[9] marks jumps (always / if Z / if C) resolved in EXEC.
module cu_module
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [OPSIZE-1:0]    aluopcode,
  output logic [ALUWIDTH-1:0]  aluin1,
  output logic [ALUWIDTH-1:0]  aluin2,
  input  logic [ALUWIDTH-1:0]  aluout,
  input  logic [NUMFLAGS-1:0]  flags,
  input  logic [DATALINES-1:0] fromram,
  output logic [DATALINES-1:0] toram,
  output logic [ADLINES-1:0]   addressbus,
  output logic                 read,
  output logic                 write
);
  state_t               r_state;
  logic [ADLINES-1:0]   r_pc;
  logic [DATALINES-1:0] r_ir;
  logic [ALUWIDTH-1:0]  r_acc;
  logic [NUMFLAGS-1:0]  r_flag;
  logic                 w_run;
  logic                 w_jump;
  logic                 w_take;
  logic                 w_exec;
  logic                 w_store;
  // Strobes are qualified by rst as well so the buses are quiet for the whole reset pulse.
  assign w_run = enable & ~rst;
`ifdef CU_JUMP_EN
  assign w_jump = r_ir[JUMP_BIT];
`else
  assign w_jump = 1'b0;
`endif
  assign w_take = (r_ir[2:0] == JMP_ALWAYS) |
                  ((r_ir[2:0] == JMP_Z) & r_flag[FLAG_Z]) |
                  ((r_ir[2:0] == JMP_C) & r_flag[FLAG_C]);
  assign w_exec  = w_run & (r_state == ST_EXEC) & ~w_jump;
  assign w_store = w_run & (r_state == ST_STORE);
  always_comb begin
    aluopcode  = w_exec ? r_ir[2:0] : '0;
    aluin1     = r_acc;
    aluin2     = w_exec ? fromram : '0;
    toram      = w_store ? r_acc : '0;
    addressbus = (w_run & (r_state == ST_FETCH)) ? r_pc :
                 (w_exec | w_store) ? r_ir[7:3] : '0;
    read       = (w_run & (r_state == ST_FETCH)) | w_exec;
    write      = w_store;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= ADLINES'(1);
      r_ir    <= '0;
      r_acc   <= '0;
      r_flag  <= '0;
    end else if (enable) begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= fromram;
          r_pc    <= r_pc + 1'b1;
          r_state <= ST_DECODE;
        end
        ST_DECODE: r_state <= (r_ir == HALT_WORD) ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          if (w_jump) begin
            if (w_take) r_pc <= r_ir[7:3];
            r_state <= ST_FETCH;
          end else begin
            r_acc   <= aluout;
            r_flag  <= flags;
            r_state <= r_ir[STORE_BIT] ? ST_STORE : ST_FETCH;
          end
        end
        ST_STORE: r_state <= ST_FETCH;
        default:  r_state <= ST_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_cu_module.sv
// tb_cu_module: directed programs on cu_module + alu_module + bench RAM, scoreboarded
module tb_cu_module;
  import cpu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  aluopcode;
  logic [15:0] aluin1, aluin2, aluout, fromram, toram;
  logic [3:0]  flags;
  logic [4:0]  addressbus;
  logic        read, write;
  logic [15:0] mem [32];
  logic [15:0] img [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [31:0] acc_q [$];
  logic [20:0] wr_q [$];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cu_module dut (
    .clk(clk), .rst(rst), .enable(enable), .aluopcode(aluopcode), .aluin1(aluin1),
    .aluin2(aluin2), .aluout(aluout), .flags(flags), .fromram(fromram), .toram(toram),
    .addressbus(addressbus), .read(read), .write(write)
  );
  alu_module alu (.i_a(aluin1), .i_b(aluin2), .i_op(aluopcode), .o_result(aluout), .o_flags(flags));

  assign fromram = read ? mem[addressbus] : '0;
  always @(posedge clk)
    if (write) mem[addressbus] <= toram;
    else if (ld_en) mem[ld_addr] <= ld_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  always @(negedge clk)
    if (write) begin
      if (wr_q.size() == 0) chk("unexpected_write", {11'b0, addressbus, toram}, 32'hFFFF_FFFF);
      else chk("ram_write", {11'b0, addressbus, toram}, {11'b0, wr_q.pop_front()});
      chk("rd_wr_exclusive", {31'b0, read}, 32'd0);
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_acc(input logic [3:0] f, input logic [15:0] a);
    acc_q.push_back({12'b0, f, a});
  endtask

  task automatic check_acc(input int cycles);
    step(cycles);
    chk("acc_flags", {12'b0, dut.r_flag, aluin1}, acc_q.pop_front());
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = '0;
  endtask

  task automatic apply();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ld_addr = 5'(i);
      ld_data = img[i];
      ld_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    ld_en = 1'b0;
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_addr", {27'b0, addressbus}, 32'd0);
    chk("rst_acc", {16'b0, aluin1}, 32'd0);
    chk("rst_pc", {27'b0, dut.r_pc}, 32'd1);
    rst = 1'b0;
  endtask

  task automatic image_add_store();
    clear_img();
    img[16] = 16'd5;
    img[17] = 16'd2;
    img[1]  = 16'h0086;
    img[2]  = 16'h018E;
  endtask

  initial begin
    // add then add-and-store, then halt
    image_add_store();
    apply();
    push_acc(4'b0000, 16'd5);
    push_acc(4'b0000, 16'd7);
    wr_q.push_back({5'd17, 16'd7});
    check_acc(3);
    check_acc(3);
    step(2);
    chk("pre_halt_state", 32'(dut.r_state), 32'(ST_DECODE));
    step(1);
    chk("halt_state", 32'(dut.r_state), 32'(ST_HALT));
    step(3);
    chk("halt_held", 32'(dut.r_state), 32'(ST_HALT));
    chk("halt_read", {31'b0, read}, 32'd0);
    chk("halt_pc", {27'b0, dut.r_pc}, 32'd4);
    chk("stored_word", {16'b0, mem[17]}, 32'd7);

    // PASS, SUB to zero, SUB borrowing
    clear_img();
    img[16] = 16'd9;
    img[17] = 16'd1;
    img[1]  = 16'h0080;
    img[2]  = 16'h0085;
    img[3]  = 16'h008D;
    apply();
    push_acc(4'b0000, 16'd9);
    push_acc(4'b0001, 16'h0000);
    push_acc(4'b0110, 16'hFFFF);
    while (acc_q.size() != 0) check_acc(3);
    step(2);
    chk("sub_halt", 32'(dut.r_state), 32'(ST_HALT));

    // ADD overflow/carry plus the remaining ALU ops
    clear_img();
    img[16] = 16'h7FFF;
    img[17] = 16'h0001;
    img[18] = 16'h7FFF;
    img[19] = 16'hC001;
    img[1]  = 16'h0080; push_acc(4'b0000, 16'h7FFF);
    img[2]  = 16'h008E; push_acc(4'b1100, 16'h8000);
    img[3]  = 16'h0096; push_acc(4'b0100, 16'hFFFF);
    img[4]  = 16'h008E; push_acc(4'b0011, 16'h0000);
    img[5]  = 16'h0098; push_acc(4'b0100, 16'hC001);
    img[6]  = 16'h009F; push_acc(4'b0110, 16'h8002);
    img[7]  = 16'h009B; push_acc(4'b0000, 16'h4003);
    img[8]  = 16'h009C; push_acc(4'b0100, 16'hBFFC);
    img[9]  = 16'h0099; push_acc(4'b0100, 16'h8000);
    img[10] = 16'h009A; push_acc(4'b0100, 16'hC001);
    apply();
    while (acc_q.size() != 0) check_acc(3);

    // enable dropped for 5 cycles while in EXEC
    image_add_store();
    apply();
    step(2);
    chk("exec_reached", 32'(dut.r_state), 32'(ST_EXEC));
    enable = 1'b0;
    #1;
    chk("frozen_read", {31'b0, read}, 32'd0);
    step(5);
    chk("frozen_state", 32'(dut.r_state), 32'(ST_EXEC));
    chk("frozen_read2", {31'b0, read}, 32'd0);
    chk("frozen_acc", {16'b0, aluin1}, 32'd0);
    chk("frozen_pc", {27'b0, dut.r_pc}, 32'd2);
    enable = 1'b1;
    push_acc(4'b0000, 16'd5);
    push_acc(4'b0000, 16'd7);
    wr_q.push_back({5'd17, 16'd7});
    check_acc(1);
    check_acc(3);
    step(3);
    chk("resume_halt", 32'(dut.r_state), 32'(ST_HALT));

    // reset pulse in the middle of STORE
    image_add_store();
    apply();
    wr_q.push_back({5'd17, 16'd7});
    step(6);
    chk("store_write", {31'b0, write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_write_drop", {31'b0, write}, 32'd0);
    chk("rst_mid_pc", {27'b0, dut.r_pc}, 32'd1);
    chk("rst_mid_acc", {16'b0, aluin1}, 32'd0);
    step(2);
    chk("target_unchanged", {16'b0, mem[17]}, 32'd2);
    chk("writes_drained", wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
